// File: rtl/bp_pkg.sv
// Shared sizing and 2-bit counter encodings for branch_predictor64.
package bp_pkg;
  localparam int XLEN    = 64;
  localparam int ENTRIES = 64;
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int TAG_W   = 10;

  typedef logic [1:0] ctr_t;
  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    ctr_t             ctr;
  } entry_t;
endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t next
);
  always_comb begin
    next = ctr;
    if (taken) begin
      if (ctr != ST) next = ctr + 2'd1;
    end else begin
      if (ctr != SNT) next = ctr - 2'd1;
    end
  end
endmodule

// File: rtl/branch_predictor64.sv
// Direct-mapped 2-bit counter predictor with BTB and registered mispredict redirect.
// Optional global-history (gshare) indexing is enabled with BP_GSHARE_EN.
module branch_predictor64
  import bp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
`ifdef BP_GSHARE_EN
  output logic [IDX_W-1:0] pred_idx,
  input  logic [IDX_W-1:0] ex_idx,
`endif
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_bre,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);
  entry_t           tbl [ENTRIES];
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  entry_t           lk_e, up_e;
  logic             up_hit;
  ctr_t             ctr_next;
  logic             mispredict;

  assign lk_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr;
  assign lk_idx   = if_pc[IDX_W+1:2] ^ ghr;
  assign up_idx   = ex_idx;
  assign pred_idx = lk_idx;

  // History shifts on every resolved branch, mispredicted or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ghr <= '0;
    else if (ex_valid) ghr <= {ghr[IDX_W-2:0], ex_bre};
  end
`else
  assign lk_idx = if_pc[IDX_W+1:2];
  assign up_idx = ex_pc[IDX_W+1:2];
`endif

  // Lookup reads the registered table only: no bypass from a same-cycle update.
  assign lk_e        = tbl[lk_idx];
  assign pred_hit    = lk_e.valid && (lk_e.tag == lk_tag);
  assign pred_taken  = pred_hit && lk_e.ctr[1];
  assign pred_target = pred_taken ? lk_e.target : if_pc + XLEN'(4);

  assign up_e   = tbl[up_idx];
  assign up_hit = up_e.valid && (up_e.tag == up_tag);

  sat_counter2 u_ctr (
    .ctr   (up_e.ctr),
    .taken (ex_bre),
    .next  (ctr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else if (ex_valid) begin
      if (up_hit) begin
        tbl[up_idx].ctr <= ctr_next;
        if (ex_bre) tbl[up_idx].target <= ex_target;
      end else if (ex_bre) begin
        // Allocation replaces whatever aliased entry lives at this index.
        tbl[up_idx] <= '{valid: 1'b1, tag: up_tag, target: ex_target, ctr: WT};
      end
    end
  end

  assign mispredict = ex_valid &&
                      ((ex_bre != ex_pred_taken) ||
                       (ex_bre && (ex_target != ex_pred_target)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= mispredict;
      if (mispredict) redirect_pc <= ex_bre ? ex_target : ex_pc + XLEN'(4);
    end
  end
endmodule

// File: tb/tb_branch_predictor64.sv
// Bench for branch_predictor64: directed vector table, async-reset sequence, randomized model check.
module tb_branch_predictor64;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [63:0] pred_target;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic        ex_bre;
  logic [63:0] ex_target;
  logic        ex_pred_taken;
  logic [63:0] ex_pred_target;
  logic        redirect;
  logic [63:0] redirect_pc;

  int vec_count  = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  branch_predictor64 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_bre         (ex_bre),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
  );

  typedef struct {
    logic        ex_valid;
    logic [63:0] ex_pc;
    logic        ex_bre;
    logic [63:0] ex_target;
    logic        ex_pred_taken;
    logic [63:0] ex_pred_target;
    logic [63:0] if_pc;
    logic        hit;
    logic        taken;
    logic [63:0] target;
    logic        rd;
    logic [63:0] rpc;
  } vec_t;

  // Reference model: one record per table slot, counter kept as a plain integer 0..3.
  bit          m_valid [64];
  int          m_tag   [64];
  logic [63:0] m_target[64];
  int          m_ctr   [64];
  logic        m_rd;
  logic [63:0] m_rpc;

  function automatic int slot_of(logic [63:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int tag_of(logic [63:0] pc);
    return int'((pc / 256) % 1024);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i]  = 0;
      m_tag[i]    = 0;
      m_target[i] = '0;
      m_ctr[i]    = 1;
    end
    m_rd  = 1'b0;
    m_rpc = '0;
  endtask

  task automatic m_lookup(input logic [63:0] pc, output logic hit, output logic taken,
                          output logic [63:0] tgt);
    int s;
    s     = slot_of(pc);
    hit   = m_valid[s] && (m_tag[s] == tag_of(pc));
    taken = hit && (m_ctr[s] >= 2);
    tgt   = taken ? m_target[s] : pc + 64'd4;
  endtask

  task automatic m_step(input vec_t v);
    int s;
    bit hit, wrong;
    s     = slot_of(v.ex_pc);
    wrong = v.ex_valid && ((v.ex_bre != v.ex_pred_taken) ||
                           (v.ex_bre && v.ex_target != v.ex_pred_target));
    m_rd  = wrong;
    if (wrong) m_rpc = v.ex_bre ? v.ex_target : v.ex_pc + 64'd4;
    if (v.ex_valid) begin
      hit = m_valid[s] && (m_tag[s] == tag_of(v.ex_pc));
      if (hit && v.ex_bre) begin
        m_ctr[s]    = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
        m_target[s] = v.ex_target;
      end else if (hit) begin
        m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
      end else if (v.ex_bre) begin
        m_valid[s]  = 1;
        m_tag[s]    = tag_of(v.ex_pc);
        m_target[s] = v.ex_target;
        m_ctr[s]    = 2;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge: drives one cycle, returns pre-edge lookup and post-edge redirect.
  task automatic drive_cycle(input vec_t v, output logic hit, output logic taken,
                             output logic [63:0] tgt, output logic rd, output logic [63:0] rpc);
    ex_valid       = v.ex_valid;
    ex_pc          = v.ex_pc;
    ex_bre         = v.ex_bre;
    ex_target      = v.ex_target;
    ex_pred_taken  = v.ex_pred_taken;
    ex_pred_target = v.ex_pred_target;
    if_pc          = v.if_pc;
    #1;
    hit   = pred_hit;
    taken = pred_taken;
    tgt   = pred_target;
    @(posedge clk);
    #1;
    rd  = redirect;
    rpc = redirect_pc;
  endtask

  function automatic vec_t mk(logic ev, logic [63:0] epc, logic bre, logic [63:0] etgt,
                              logic ept, logic [63:0] eptgt, logic [63:0] ipc, logic h,
                              logic t, logic [63:0] tg, logic r, logic [63:0] rp);
    vec_t v;
    v.ex_valid = ev; v.ex_pc = epc; v.ex_bre = bre; v.ex_target = etgt;
    v.ex_pred_taken = ept; v.ex_pred_target = eptgt; v.if_pc = ipc;
    v.hit = h; v.taken = t; v.target = tg; v.rd = r; v.rpc = rp;
    return v;
  endfunction

  vec_t vt[15];

  initial begin
    logic        h, t, r;
    logic [63:0] tg, rp;
    vec_t        v;

    // Lookup columns are pre-edge; redirect columns are after the edge.
    vt[0]  = mk(0, 64'h0,    0, 64'h0,    0, 64'h0,    64'h1000, 0, 0, 64'h1004, 0, 64'h0);
    vt[1]  = mk(1, 64'h1000, 1, 64'h0F00, 0, 64'h1004, 64'h1000, 0, 0, 64'h1004, 1, 64'h0F00);
    vt[2]  = mk(0, 64'h0,    0, 64'h0,    0, 64'h0,    64'h1000, 1, 1, 64'h0F00, 0, 64'h0F00);
    vt[3]  = mk(1, 64'h1000, 1, 64'h0F00, 1, 64'h0F00, 64'h1000, 1, 1, 64'h0F00, 0, 64'h0F00);
    vt[4]  = mk(1, 64'h1000, 1, 64'h0F00, 1, 64'h0F00, 64'h1000, 1, 1, 64'h0F00, 0, 64'h0F00);
    vt[5]  = mk(1, 64'h1000, 1, 64'h0F00, 1, 64'h0F00, 64'h1000, 1, 1, 64'h0F00, 0, 64'h0F00);
    vt[6]  = mk(1, 64'h1000, 0, 64'h0F00, 1, 64'h0F00, 64'h1000, 1, 1, 64'h0F00, 1, 64'h1004);
    vt[7]  = mk(1, 64'h1000, 0, 64'h0F00, 1, 64'h0F00, 64'h1000, 1, 1, 64'h0F00, 1, 64'h1004);
    vt[8]  = mk(0, 64'h0,    0, 64'h0,    0, 64'h0,    64'h1000, 1, 0, 64'h1004, 0, 64'h1004);
    vt[9]  = mk(1, 64'h1000, 1, 64'h3000, 1, 64'h2000, 64'h1000, 1, 0, 64'h1004, 1, 64'h3000);
    vt[10] = mk(1, 64'h1100, 1, 64'h4000, 0, 64'h1104, 64'h1000, 1, 1, 64'h3000, 1, 64'h4000);
    vt[11] = mk(0, 64'h0,    0, 64'h0,    0, 64'h0,    64'h1000, 0, 0, 64'h1004, 0, 64'h4000);
    vt[12] = mk(0, 64'h0,    0, 64'h0,    0, 64'h0,    64'h1100, 1, 1, 64'h4000, 0, 64'h4000);
    vt[13] = mk(0, 64'h0,    0, 64'h0,    0, 64'h0,    64'h1102, 1, 1, 64'h4000, 0, 64'h4000);
    vt[14] = mk(0, 64'h0,    0, 64'h0,    0, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0, 0, 64'h4000);

    // Clock/reset
    rst_n = 1'b0; ex_valid = 0; ex_pc = '0; ex_bre = 0; ex_target = '0;
    ex_pred_taken = 0; ex_pred_target = '0; if_pc = 64'h1000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_redirect", {63'd0, redirect}, 64'd0);
    chk("reset_redirect_pc", redirect_pc, 64'd0);

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      drive_cycle(vt[i], h, t, tg, r, rp);
      chk($sformatf("vec%0d_hit", i),    {63'd0, h}, {63'd0, vt[i].hit});
      chk($sformatf("vec%0d_taken", i),  {63'd0, t}, {63'd0, vt[i].taken});
      chk($sformatf("vec%0d_target", i), tg, vt[i].target);
      chk($sformatf("vec%0d_redirect", i), {63'd0, r}, {63'd0, vt[i].rd});
      chk($sformatf("vec%0d_redirect_pc", i), rp, vt[i].rpc);
    end

    // Async reset landing on the cycle a redirect would fire
    ex_valid = 1; ex_pc = 64'h1100; ex_bre = 0; ex_target = 64'h0;
    ex_pred_taken = 1; ex_pred_target = 64'h4000; if_pc = 64'h1100;
    #1 chk("prereset_hit", {63'd0, pred_hit}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_hit", {63'd0, pred_hit}, 64'd0);
    chk("midreset_target", pred_target, 64'h1104);
    chk("midreset_redirect_pc", redirect_pc, 64'd0);
    @(posedge clk); #1;
    chk("midreset_redirect", {63'd0, redirect}, 64'd0);
    ex_valid = 0; rst_n = 1'b1; if_pc = 64'h1000;
    #1 chk("postreset_hit", {63'd0, pred_hit}, 64'd0);
    @(posedge clk); #1;
    chk("postreset_redirect", {63'd0, redirect}, 64'd0);

    // Randomized run against the model
    m_reset();
    for (int n = 0; n < 600; n++) begin
      logic        mh, mt;
      logic [63:0] mtg;
      v.ex_valid  = ($urandom_range(0, 3) != 0);
      v.ex_pc     = 64'h1000 + 64'($urandom_range(0, 3)) * 256 + 64'($urandom_range(0, 7)) * 4;
      v.ex_bre    = $urandom_range(0, 1);
      v.ex_target = 64'h8000 + 64'($urandom_range(0, 3)) * 64'h100;
      m_lookup(v.ex_pc, mh, mt, mtg);
      if ($urandom_range(0, 3) != 0) begin
        v.ex_pred_taken  = mt;
        v.ex_pred_target = mtg;
      end else begin
        v.ex_pred_taken  = $urandom_range(0, 1);
        v.ex_pred_target = 64'h8000 + 64'($urandom_range(0, 3)) * 64'h100;
      end
      v.if_pc = 64'h1000 + 64'($urandom_range(0, 3)) * 256 + 64'($urandom_range(0, 31));
      m_lookup(v.if_pc, mh, mt, mtg);
      m_step(v);
      drive_cycle(v, h, t, tg, r, rp);
      chk("rand_hit",    {63'd0, h}, {63'd0, mh});
      chk("rand_taken",  {63'd0, t}, {63'd0, mt});
      chk("rand_target", tg, mtg);
      chk("rand_redirect", {63'd0, r}, {63'd0, m_rd});
      chk("rand_redirect_pc", rp, m_rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end
endmodule
